// File: rtl/mmcm_drp_ctrl_if.sv
// DRP bus between the mode-reconfiguration controller (master) and the MMCM DRP port (slave).
interface mmcm_drp_ctrl_if;
  logic        drp_den;
  logic        drp_dwe;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_drdy;

  modport master (
    output drp_den, drp_dwe, drp_daddr, drp_di,
    input  drp_do, drp_drdy
  );

  modport slave (
    input  drp_den, drp_dwe, drp_daddr, drp_di,
    output drp_do, drp_drdy
  );
endinterface

// File: rtl/mmcm_drp_ctrl.sv
// HDMI pixel-clock MMCM mode switcher: holds the MMCM in reset, read-modify-writes each
// entry of an external per-mode DRP table, releases reset and waits for LOCKED.
module mmcm_drp_ctrl #(
  parameter int  N_REG        = 23,
  parameter int  MODE_W       = 2,
  parameter int  DRP_TIMEOUT  = 255,
  parameter int  LOCK_TIMEOUT = 65535,
  localparam int IDX_W        = (N_REG > 1) ? $clog2(N_REG) : 1
) (
  input  logic              clk_ext,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [MODE_W-1:0] req_mode,
  output logic              req_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [MODE_W-1:0] cur_mode,
  output logic [MODE_W-1:0] tbl_mode,
  output logic [IDX_W-1:0]  tbl_idx,
  input  logic [6:0]        tbl_addr,
  input  logic [15:0]       tbl_mask,
  input  logic [15:0]       tbl_data,
  mmcm_drp_ctrl_if.master   drp,
  output logic              mmcm_rst,
  input  logic              mmcm_locked
);

  localparam int CNT_MAX = (DRP_TIMEOUT > LOCK_TIMEOUT) ? DRP_TIMEOUT : LOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // The counter holds the number of cycles already spent in the current wait state,
  // so a wait gives up after exactly *_TIMEOUT cycles.
  localparam logic [CNT_W-1:0] DRP_LAST  = CNT_W'(DRP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_REG - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ASSERT,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_WR_WAIT,
    S_RELEASE,
    S_LOCK_WAIT,
    S_DONE
  } state_t;

  state_t            state_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [MODE_W-1:0] cur_mode_q;
  logic [MODE_W-1:0] tbl_mode_q;
  logic [IDX_W-1:0]  tbl_idx_q;
  logic              den_q;
  logic              dwe_q;
  logic [6:0]        daddr_q;
  logic [15:0]       di_q;
  logic [15:0]       mask_q;
  logic [15:0]       data_q;
  logic              mmcm_rst_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        lock_sync_q;
  logic              locked_s;

  // LOCKED comes from the MMCM's own analog lock detector, unrelated to clk_ext.
  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) lock_sync_q <= '0;
    else        lock_sync_q <= {lock_sync_q[0], mmcm_locked};
  end

  assign locked_s = lock_sync_q[1];

  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cur_mode_q <= '0;
      tbl_mode_q <= '0;
      tbl_idx_q  <= '0;
      den_q      <= 1'b0;
      dwe_q      <= 1'b0;
      daddr_q    <= '0;
      di_q       <= '0;
      mask_q     <= '0;
      data_q     <= '0;
      mmcm_rst_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      // NOTE: the DRP strobes default low here so each access is a single-cycle pulse;
      // only RD and WR raise them. Non-blocking assignments keep every register
      // reading the pre-edge value of the others.
      den_q <= 1'b0;
      dwe_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            tbl_mode_q <= req_mode;
            tbl_idx_q  <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            ready_q    <= 1'b0;
            state_q    <= S_ASSERT;
          end
        end

        S_ASSERT: begin
          mmcm_rst_q <= 1'b1;
          state_q    <= S_RD;
        end

        S_RD: begin
          daddr_q <= tbl_addr;
          mask_q  <= tbl_mask;
          data_q  <= tbl_data;
          den_q   <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_RD_WAIT;
        end

        S_RD_WAIT: begin
          if (drp.drp_drdy) begin
            di_q    <= (drp.drp_do & mask_q) | (data_q & ~mask_q);
            state_q <= S_WR;
          end else if (cnt_q == DRP_LAST) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_WR: begin
          den_q   <= 1'b1;
          dwe_q   <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_WR_WAIT;
        end

        S_WR_WAIT: begin
          if (drp.drp_drdy) begin
            if (tbl_idx_q == IDX_LAST) begin
              state_q <= S_RELEASE;
            end else begin
              tbl_idx_q <= tbl_idx_q + 1'b1;
              state_q   <= S_RD;
            end
          end else if (cnt_q == DRP_LAST) begin
            // MMCM contents are unknown after a stuck DRP, so it stays in reset.
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_RELEASE: begin
          mmcm_rst_q <= 1'b0;
          cnt_q      <= '0;
          state_q    <= S_LOCK_WAIT;
        end

        S_LOCK_WAIT: begin
          if (locked_s) begin
            cur_mode_q <= tbl_mode_q;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end else if (cnt_q == LOCK_LAST) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign cur_mode      = cur_mode_q;
  assign tbl_mode      = tbl_mode_q;
  assign tbl_idx       = tbl_idx_q;
  assign mmcm_rst      = mmcm_rst_q;
  assign drp.drp_den   = den_q;
  assign drp.drp_dwe   = dwe_q;
  assign drp.drp_daddr = daddr_q;
  assign drp.drp_di    = di_q;

endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// Self-checking bench for mmcm_drp_ctrl: DRP slave with access scoreboard, MMCM lock
// model, per-cycle protocol checks and directed scenarios with hand-computed timing.
module tb_mmcm_drp_ctrl;

  localparam int N_REG   = 4;
  localparam int MODE_W  = 2;
  localparam int DRP_TO  = 16;
  localparam int LOCK_TO = 100;
  localparam int IDX_W   = 2;

  logic              clk_ext = 1'b0;
  logic              rst_n   = 1'b0;
  logic              req_valid;
  logic [MODE_W-1:0] req_mode;
  logic              req_ready;
  logic              busy;
  logic              done;
  logic              err;
  logic [MODE_W-1:0] cur_mode;
  logic [MODE_W-1:0] tbl_mode;
  logic [IDX_W-1:0]  tbl_idx;
  logic [6:0]        tbl_addr;
  logic [15:0]       tbl_mask;
  logic [15:0]       tbl_data;
  logic              mmcm_rst;
  logic              mmcm_locked = 1'b0;

  mmcm_drp_ctrl_if drp_bus ();

  always #5 clk_ext = ~clk_ext;

  mmcm_drp_ctrl #(
    .N_REG       (N_REG),
    .MODE_W      (MODE_W),
    .DRP_TIMEOUT (DRP_TO),
    .LOCK_TIMEOUT(LOCK_TO)
  ) dut (
    .clk_ext    (clk_ext),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_mode   (req_mode),
    .req_ready  (req_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cur_mode   (cur_mode),
    .tbl_mode   (tbl_mode),
    .tbl_idx    (tbl_idx),
    .tbl_addr   (tbl_addr),
    .tbl_mask   (tbl_mask),
    .tbl_data   (tbl_data),
    .drp        (drp_bus),
    .mmcm_rst   (mmcm_rst),
    .mmcm_locked(mmcm_locked)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- register table ROM ----------------
  function automatic logic [6:0] rom_addr(input int m, input int i);
    return 7'(16 * m + 8 + i);
  endfunction

  function automatic logic [15:0] rom_mask(input int m, input int i);
    return (m == 2) ? 16'hF000 : 16'(32'h00FF << (4 * i));
  endfunction

  function automatic logic [15:0] rom_data(input int m, input int i);
    return (m == 2) ? 16'h0123 : 16'(32'hA5C3 ^ (i * 32'h1111) ^ m);
  endfunction

  assign tbl_addr = rom_addr(int'(tbl_mode), int'(tbl_idx));
  assign tbl_mask = rom_mask(int'(tbl_mode), int'(tbl_idx));
  assign tbl_data = rom_data(int'(tbl_mode), int'(tbl_idx));

  // ---------------- expected DRP access scoreboard ----------------
  typedef struct {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
  } acc_t;

  acc_t exp_q[$];

  task automatic expect_seq(input int m);
    for (int i = 0; i < N_REG; i++) begin
      exp_q.push_back('{1'b0, rom_addr(m, i), rom_mask(m, i), rom_data(m, i)});
      exp_q.push_back('{1'b1, rom_addr(m, i), rom_mask(m, i), rom_data(m, i)});
    end
  endtask

  // ---------------- DRP slave model ----------------
  logic [15:0] mem [128];
  logic [15:0] last_rd = '0;
  logic [15:0] wr_log[$];
  int  rd_lat   = 2;
  int  wr_lat   = 2;
  int  stall_at = -1;
  int  acc_num  = 0;
  int  pend_cnt = 0;
  bit  pend     = 1'b0;
  bit  noise    = 1'b0;
  logic [6:0] pend_addr = '0;

  always @(negedge clk_ext) begin
    acc_t e;
    drp_bus.drp_drdy = 1'b0;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          drp_bus.drp_drdy = 1'b1;
          drp_bus.drp_do   = mem[pend_addr];
          last_rd          = mem[pend_addr];
          pend             = 1'b0;
        end
      end
      if (noise) begin
        drp_bus.drp_drdy = 1'b1;
        drp_bus.drp_do   = 16'($urandom);
      end
      if (drp_bus.drp_den) begin
        check("one_outstanding", 32'(pend), 32'd0);
        check("access_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("drp_we", 32'(drp_bus.drp_dwe), 32'(e.we));
          check("drp_addr", 32'(drp_bus.drp_daddr), 32'(e.addr));
          if (drp_bus.drp_dwe) begin
            check("drp_di", 32'(drp_bus.drp_di), 32'((last_rd & e.mask) | (e.data & ~e.mask)));
            mem[drp_bus.drp_daddr] = drp_bus.drp_di;
            wr_log.push_back(drp_bus.drp_di);
          end
        end
        if (acc_num != stall_at) begin
          pend      = 1'b1;
          pend_cnt  = drp_bus.drp_dwe ? wr_lat : rd_lat;
          pend_addr = drp_bus.drp_daddr;
        end
        acc_num++;
      end
    end
  end

  // ---------------- MMCM lock model ----------------
  int lock_delay = 50;
  int lock_cnt   = 50;
  bit lock_en    = 1'b1;

  always @(negedge clk_ext) begin
    if (mmcm_rst) lock_cnt = 0;
    else if (lock_cnt < lock_delay) lock_cnt++;
    mmcm_locked = lock_en && (lock_cnt >= lock_delay);
  end

  // ---------------- per-cycle compare against the model ----------------
  logic [MODE_W-1:0] exp_mode     = '0;
  logic [MODE_W-1:0] exp_cur_mode = '0;
  logic              exp_err      = 1'b0;
  logic              den_prev     = 1'b0;
  logic              done_prev    = 1'b0;
  int                done_cnt     = 0;

  always @(negedge clk_ext) begin
    if (rst_n) begin
      check("ready_is_not_busy", 32'(req_ready), 32'(!busy));
      if (drp_bus.drp_dwe) check("dwe_only_with_den", 32'(drp_bus.drp_den), 32'd1);
      if (drp_bus.drp_den) begin
        check("mmcm_rst_during_drp", 32'(mmcm_rst), 32'd1);
        check("den_single_cycle", 32'(den_prev), 32'd0);
        check("tbl_mode", 32'(tbl_mode), 32'(exp_mode));
      end
      if (done) begin
        check("done_single_pulse", 32'(done_prev), 32'd0);
        check("busy_with_done", 32'(busy), 32'd1);
        done_cnt++;
      end
      if (!busy) begin
        check("cur_mode", 32'(cur_mode), 32'(exp_cur_mode));
        check("err", 32'(err), 32'(exp_err));
      end
      den_prev  = drp_bus.drp_den;
      done_prev = done;
    end else begin
      den_prev  = 1'b0;
      done_prev = 1'b0;
    end
  end

  // ---------------- scenario helpers ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_cur_mode"}, 32'(cur_mode), 32'd0);
    check({tag, "_tbl_mode"}, 32'(tbl_mode), 32'd0);
    check({tag, "_tbl_idx"}, 32'(tbl_idx), 32'd0);
    check({tag, "_den"}, 32'(drp_bus.drp_den), 32'd0);
    check({tag, "_dwe"}, 32'(drp_bus.drp_dwe), 32'd0);
    check({tag, "_daddr"}, 32'(drp_bus.drp_daddr), 32'd0);
    check({tag, "_di"}, 32'(drp_bus.drp_di), 32'd0);
    check({tag, "_mmcm_rst"}, 32'(mmcm_rst), 32'd0);
  endtask

  // Drives a request and pins accept timing: busy after N, mmcm_rst after N+1, den after N+2.
  task automatic request(input int m, input bit ok, input bit hold);
    @(negedge clk_ext);
    req_valid = 1'b1;
    req_mode  = MODE_W'(m);
    @(negedge clk_ext);
    check("busy_after_accept", 32'(busy), 32'd1);
    check("err_cleared_on_accept", 32'(err), 32'd0);
    if (!hold) req_valid = 1'b0;
    exp_mode = MODE_W'(m);
    if (ok) begin
      exp_cur_mode = MODE_W'(m);
      exp_err      = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
    expect_seq(m);
    @(negedge clk_ext);
    check("mmcm_rst_after_assert", 32'(mmcm_rst), 32'd1);
    check("no_den_in_assert", 32'(drp_bus.drp_den), 32'd0);
    @(negedge clk_ext);
    check("first_den", 32'(drp_bus.drp_den), 32'd1);
    check("first_daddr", 32'(drp_bus.drp_daddr), 32'(rom_addr(m, 0)));
  endtask

  task automatic run_to_done(input int limit, output int rst_low_at, output int den_at,
                             output int done_at);
    rst_low_at = -1;
    den_at     = -1;
    done_at    = -1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk_ext);
      if (drp_bus.drp_den) den_at = k;
      if (!mmcm_rst && rst_low_at < 0) rst_low_at = k;
      if (done) begin
        done_at = k;
        break;
      end
    end
    check("done_within_budget", 32'(done_at >= 0), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rst_low_at, den_at, done_at, dc;
    bit found;

    req_valid        = 1'b0;
    req_mode         = '0;
    drp_bus.drp_do   = '0;
    drp_bus.drp_drdy = 1'b0;
    for (int a = 0; a < 128; a++) mem[a] = 16'hFFFF;

    // Reset state
    repeat (3) @(negedge clk_ext);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk_ext);
    check("ready_after_reset", 32'(req_ready), 32'd1);

    // Lock timeout: LOCKED never returns, cur_mode stays 0
    lock_en = 1'b0;
    request(1, 1'b0, 1'b0);
    run_to_done(600, rst_low_at, den_at, done_at);
    check("lock_timeout_cycles", 32'(done_at - rst_low_at), 32'd100);
    @(negedge clk_ext);
    check("lock_to_err", 32'(err), 32'd1);
    check("lock_to_mmcm_rst_low", 32'(mmcm_rst), 32'd0);
    check("lock_to_cur_mode", 32'(cur_mode), 32'd0);
    lock_en = 1'b1;

    // Normal switch to mode 2, drp_do=FFFF, mask F000, data 0123, lock after 50 cycles
    wr_log.delete();
    dc = done_cnt;
    request(2, 1'b1, 1'b0);
    run_to_done(600, rst_low_at, den_at, done_at);
    check("lock_to_done_latency", 32'(done_at - rst_low_at), 32'd52);
    @(negedge clk_ext);
    check("normal_ready_after_done", 32'(req_ready), 32'd1);
    check("normal_cur_mode", 32'(cur_mode), 32'd2);
    check("normal_err", 32'(err), 32'd0);
    check("normal_done_pulses", 32'(done_cnt - dc), 32'd1);
    check("normal_write_count", 32'(wr_log.size()), 32'd4);
    foreach (wr_log[i]) check("normal_write_data", 32'(wr_log[i]), 32'h0000_F123);
    check("normal_all_accesses", 32'(exp_q.size()), 32'd0);

    // DRP timeout on the read of entry 1 (third access)
    stall_at = acc_num + 2;
    request(3, 1'b0, 1'b0);
    run_to_done(600, rst_low_at, den_at, done_at);
    check("drp_timeout_cycles", 32'(done_at - den_at), 32'd16);
    check("drp_to_rst_never_low", 32'(rst_low_at), 32'hFFFF_FFFF);
    @(negedge clk_ext);
    check("drp_to_err", 32'(err), 32'd1);
    check("drp_to_mmcm_rst_held", 32'(mmcm_rst), 32'd1);
    check("drp_to_cur_mode", 32'(cur_mode), 32'd2);
    check("drp_to_remaining", 32'(exp_q.size()), 32'd5);
    exp_q.delete();
    stall_at = -1;

    // Next request clears err; asymmetric DRP latencies
    rd_lat = 1;
    wr_lat = 3;
    request(0, 1'b1, 1'b0);
    run_to_done(600, rst_low_at, den_at, done_at);
    @(negedge clk_ext);
    check("recover_err", 32'(err), 32'd0);
    check("recover_cur_mode", 32'(cur_mode), 32'd0);
    check("recover_all_accesses", 32'(exp_q.size()), 32'd0);
    rd_lat = 2;
    wr_lat = 2;

    // Noise in IDLE, then req_valid held high across a whole sequence
    noise = 1'b1;
    repeat (5) @(negedge clk_ext);
    noise = 1'b0;
    @(negedge clk_ext);
    check("noise_still_idle", 32'(busy), 32'd0);
    dc = done_cnt;
    request(1, 1'b1, 1'b1);
    run_to_done(600, rst_low_at, den_at, done_at);
    @(negedge clk_ext);
    check("idle_between_requests", 32'(req_ready), 32'd1);
    @(negedge clk_ext);
    check("back_to_back_accept", 32'(busy), 32'd1);
    expect_seq(1);
    req_valid = 1'b0;
    run_to_done(600, rst_low_at, den_at, done_at);
    @(negedge clk_ext);
    check("contention_done_pulses", 32'(done_cnt - dc), 32'd2);
    check("contention_all_accesses", 32'(exp_q.size()), 32'd0);
    check("contention_cur_mode", 32'(cur_mode), 32'd1);

    // Reset during entry 2 WR_WAIT
    request(3, 1'b1, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_ext);
      if (drp_bus.drp_den && drp_bus.drp_dwe && tbl_idx == 2'd2) begin
        found = 1'b1;
        break;
      end
    end
    check("reached_entry2_write", 32'(found), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midop");
    exp_cur_mode = '0;
    exp_err      = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk_ext);
    rst_n = 1'b1;

    // Fresh request after reset completes normally
    request(2, 1'b1, 1'b0);
    run_to_done(600, rst_low_at, den_at, done_at);
    @(negedge clk_ext);
    check("post_reset_cur_mode", 32'(cur_mode), 32'd2);
    check("post_reset_err", 32'(err), 32'd0);
    check("post_reset_all_accesses", 32'(exp_q.size()), 32'd0);

    repeat (2) @(negedge clk_ext);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
